// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types, APB slot map and decode helper for the AHB-to-APB bridge
package bridge_pkg;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_e;
  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;
  localparam logic [31:0] SLOT0_BASE = 32'h8000_0000, SLOT0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLOT1_BASE = 32'h8400_0000, SLOT1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLOT2_BASE = 32'h8800_0000, SLOT2_LIMIT = 32'h8BFF_FFFF;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [2:0]  sel;
  } req_t;
  function automatic logic [2:0] decode(input logic [31:0] a);
    return {a >= SLOT2_BASE && a <= SLOT2_LIMIT,
            a >= SLOT1_BASE && a <= SLOT1_LIMIT,
            a >= SLOT0_BASE && a <= SLOT0_LIMIT};
  endfunction
endpackage

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-Lite address capture, decode, one-entry request buffer, Hreadyout/Hresp
// BRIDGE_ERR_RESP_EN enables the two-cycle ERROR response for unmapped addresses.
module ahb_slave_if import bridge_pkg::*; (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic        buf_clr,
  input  logic        rd_done,
  output logic        Hreadyout,
  output logic        Hresp,
  output logic        buffer_full,
  output logic        req_fire,
  output req_t        req_nxt
);
  logic        addr_phase, write_r, active;
  logic [31:0] addr_r;
  logic [2:0]  sel_r, sel;
  req_t        buf_r;
  assign sel      = decode(Haddr);
  assign active   = Hreadyin && (Htrans == HT_NONSEQ || Htrans == HT_SEQ);
  assign req_fire = addr_phase && !buffer_full;
  assign req_nxt  = req_fire ? {addr_r, Hwdata, write_r, sel_r} : buf_r;
  // a captured phase waits here until the buffer frees; the master holds Hwdata meanwhile
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) begin
      addr_phase  <= 1'b0;
      addr_r      <= '0;
      write_r     <= 1'b0;
      sel_r       <= '0;
      buf_r       <= '0;
      buffer_full <= 1'b0;
    end else begin
      if (Hreadyout) addr_phase <= active && |sel;
      else if (req_fire) addr_phase <= 1'b0;
      if (Hreadyout && active && |sel) begin
        addr_r  <= Haddr;
        write_r <= Hwrite;
        sel_r   <= sel;
      end
      if (req_fire) begin
        buf_r       <= req_nxt;
        buffer_full <= 1'b1;
      end else if (buf_clr) buffer_full <= 1'b0;
    end
`ifdef BRIDGE_ERR_RESP_EN
  logic err1, hresp_r;
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) begin
      err1    <= 1'b0;
      hresp_r <= 1'b0;
    end else begin
      err1    <= Hreadyout && active && !(|sel);
      hresp_r <= (Hreadyout && active && !(|sel)) || err1;
    end
  assign Hresp     = hresp_r;
  assign Hreadyout = !(buffer_full || (addr_phase && !write_r && !rd_done) || err1);
`else
  assign Hresp     = 1'b0;
  assign Hreadyout = !(buffer_full || (addr_phase && !write_r && !rd_done));
`endif
endmodule

// File: rtl/bridge_top.sv
// bridge_top: single-clock AHB-Lite to APB bridge with three peripheral slots
// BRIDGE_ERR_RESP_EN (in ahb_slave_if) adds the ERROR response for unmapped addresses.
module bridge_top import bridge_pkg::*; (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        Hreadyout,
  output logic        Hresp,
  output logic [31:0] Hrdata,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic        Pwrite,
  output logic        Penable,
  output logic [31:0] Pwdata
);
  req_t       req;
  logic       buffer_full, req_fire, rd_done;
  apb_state_e state;
  ahb_slave_if AHBSlave (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .buf_clr(state == APB_ACCESS), .rd_done(rd_done),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .buffer_full(buffer_full), .req_fire(req_fire),
    .req_nxt(req)
  );
  // SETUP starts on the fire edge itself, taking the request as it enters the buffer
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) begin
      state   <= APB_IDLE;
      Pselx   <= '0;
      Paddr   <= '0;
      Pwrite  <= 1'b0;
      Penable <= 1'b0;
      Pwdata  <= '0;
      Hrdata  <= '0;
      rd_done <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        APB_IDLE: if (req_fire || buffer_full) begin
          state  <= APB_SETUP;
          Pselx  <= req.sel;
          Paddr  <= req.addr;
          Pwrite <= req.write;
          Pwdata <= req.wdata;
        end
        APB_SETUP: begin
          state   <= APB_ACCESS;
          Penable <= 1'b1;
        end
        default: begin
          state   <= APB_IDLE;
          Pselx   <= '0;
          Penable <= 1'b0;
          if (!Pwrite) begin
            Hrdata  <= Prdata;
            rd_done <= 1'b1;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_bridge_top.sv
// tb_bridge_top: randomized self-checking bench for bridge_top against a transaction-level model
module tb_bridge_top;
  logic        Hclk = 1'b0, Hresetn, Hwrite, hready_en, prd_fix;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata, prd_salt;
  logic        Hreadyin, Hreadyout, Hresp, Pwrite, Penable;
  logic [31:0] Hrdata, Paddr, Pwdata;
  logic [2:0]  Pselx;
  int checks = 0, errors = 0, cyc = 0, psel_cycles = 0;
  logic setup_seen = 1'b0;

  typedef struct {logic [31:0] addr; logic wr; logic [31:0] data; logic [2:0] sel; int t;} apb_t;
  apb_t apb_q[$], exp_q[$];
  logic [31:0] x_addr[16], x_data[16], x_rdata[16];
  logic        x_wr[16];
  logic [1:0]  x_trans[16];
  int          x_wait[16];

  bridge_top dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Hrdata(Hrdata), .Pselx(Pselx), .Paddr(Paddr), .Pwrite(Pwrite), .Penable(Penable), .Pwdata(Pwdata)
  );

  assign Hreadyin = hready_en & Hreadyout;
  assign Prdata   = prd_fix ? prd_salt : (Paddr ^ prd_salt);
  always #5 Hclk = ~Hclk;
  always @(posedge Hclk) cyc <= cyc + 1;

  // APB monitor: one record per ACCESS cycle, plus SETUP-before-ACCESS protocol check
  always @(negedge Hclk) begin
    if (Pselx != 3'b000) psel_cycles++;
    if (Penable) begin
      apb_q.push_back('{Paddr, Pwrite, Pwrite ? Pwdata : Prdata, Pselx, cyc});
      checks++;
      if (!setup_seen) begin
        errors++;
        $display("FAIL apb_setup: ACCESS at cycle %0d without a preceding SETUP, required SETUP first", cyc);
      end
    end
    setup_seen = (Pselx != 3'b000) && !Penable;
  end

  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
    return 3'(1 << ((a - 32'h8000_0000) / 32'h0400_0000));
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return prd_fix ? prd_salt : (a ^ prd_salt);
  endfunction

  function automatic logic ref_err(input int i);
`ifdef BRIDGE_ERR_RESP_EN
    return x_trans[i][1] && hready_en && ref_sel(x_addr[i]) == 3'b000;
`else
    return 1'b0;
`endif
  endfunction

  // transaction model: every sampled, mapped transfer becomes one APB access, in order
  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      if (x_trans[i][1] && hready_en && ref_sel(x_addr[i]) != 3'b000)
        exp_q.push_back('{x_addr[i], x_wr[i], x_wr[i] ? x_data[i] : ref_rd(x_addr[i]), ref_sel(x_addr[i]), 0});
  endtask

  // pipelined AHB master: address of transfer a overlaps data phase of transfer d
  task automatic run_xfers(input int n);
    int a = 0, d = -1, guard = 0;
    logic rdy;
    for (int i = 0; i < n; i++) x_wait[i] = 0;
    while ((a < n || d >= 0) && guard < 50 * n + 20) begin
      @(negedge Hclk);
      guard++;
      Htrans = a < n ? x_trans[a] : 2'b00;
      Haddr  = a < n ? x_addr[a] : 32'h0;
      Hwrite = a < n ? x_wr[a] : 1'b0;
      Hwdata = (d >= 0 && x_wr[d]) ? x_data[d] : $urandom;
      rdy = Hreadyout;
      if (d >= 0) begin
        if (!rdy) x_wait[d]++;
        else begin
          x_rdata[d] = Hrdata;
          checks++;
          if (Hresp !== ref_err(d)) begin
            errors++;
            $display("FAIL hresp[%0d]: got %b, required %b", d, Hresp, ref_err(d));
          end
        end
      end
      @(posedge Hclk);
      if (rdy) begin
        d = a < n ? a : -1;
        if (a < n) a++;
      end
    end
    checks++;
    if (a < n || d >= 0) begin
      errors++;
      $display("FAIL ahb_timeout: %0d of %0d transfers accepted, required all", a, n);
    end
    @(negedge Hclk);
    Htrans = 2'b00;
  endtask

  task automatic test_reset;
    checks++;
    if ({Hreadyout, Hresp, Hrdata, Pselx, Paddr, Pwrite, Penable, Pwdata} !== {1'b1, 1'b0, 32'h0, 3'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b resp=%b rdata=%h sel=%b paddr=%h pw=%b pen=%b pwdata=%h, required 1 0 0 000 0 0 0 0",
               Hreadyout, Hresp, Hrdata, Pselx, Paddr, Pwrite, Penable, Pwdata);
    end
  endtask

  task automatic test_pipelined_writes;
    logic [31:0] ad[4] = '{32'h8000_0004, 32'h8000_00FF, 32'h8000_0011, 32'h8000_0022};
    logic [31:0] dt[4] = '{32'hA5A5_5A5A, 32'hAEAE_AEAE, 32'hFEFE_FEFE, 32'hDEAD_DEAD};
    apb_q.delete();
    for (int i = 0; i < 4; i++) begin x_addr[i] = ad[i]; x_data[i] = dt[i]; x_wr[i] = 1'b1; x_trans[i] = i == 0 ? 2'b10 : 2'b11; end
    run_xfers(4);
    repeat (6) @(negedge Hclk);
    build_exp(4);
    checks++;
    if (apb_q.size() != exp_q.size()) begin errors++; $display("FAIL writes_count: got %0d, required %0d", apb_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < apb_q.size()) begin
      checks++;
      if (apb_q[i].addr !== exp_q[i].addr || apb_q[i].wr !== exp_q[i].wr || apb_q[i].data !== exp_q[i].data || apb_q[i].sel !== exp_q[i].sel) begin
        errors++;
        $display("FAIL writes[%0d]: got %h/%b/%h/%b, required %h/%b/%h/%b", i, apb_q[i].addr, apb_q[i].wr, apb_q[i].data, apb_q[i].sel,
                 exp_q[i].addr, exp_q[i].wr, exp_q[i].data, exp_q[i].sel);
      end
    end
    for (int i = 1; i < apb_q.size(); i++) begin
      checks++;
      if (apb_q[i].t - apb_q[i-1].t != 3) begin
        errors++;
        $display("FAIL back_to_back[%0d]: spacing %0d cycles, required 3", i, apb_q[i].t - apb_q[i-1].t);
      end
    end
  endtask

  task automatic test_read;
    prd_fix = 1'b1; prd_salt = 32'hBEEF_CAFE;
    apb_q.delete();
    x_addr[0] = 32'h8400_0010; x_wr[0] = 1'b0; x_trans[0] = 2'b10;
    run_xfers(1);
    repeat (3) @(negedge Hclk);
    build_exp(1);
    checks++;
    if (x_wait[0] != 3) begin errors++; $display("FAIL read_waits: got %0d, required 3", x_wait[0]); end
    checks++;
    if (x_rdata[0] !== 32'hBEEF_CAFE) begin errors++; $display("FAIL read_data: got %h, required beefcafe", x_rdata[0]); end
    checks++;
    if (apb_q.size() != 1 || apb_q[0].sel !== 3'b010 || apb_q[0].wr !== 1'b0 || apb_q[0].addr !== exp_q[0].addr) begin
      errors++;
      $display("FAIL read_apb: got %0d accesses (first sel=%b), required 1 at %h sel=010 read", apb_q.size(),
               apb_q.size() > 0 ? apb_q[0].sel : 3'bxxx, exp_q[0].addr);
    end
    prd_fix = 1'b0;
  endtask

  task automatic test_slot2_and_oor;
    apb_q.delete();
    x_addr[0] = 32'h8800_0000; x_wr[0] = 1'b1; x_data[0] = $urandom; x_trans[0] = 2'b10;
    run_xfers(1);
    repeat (5) @(negedge Hclk);
    checks++;
    if (apb_q.size() != 1 || apb_q[0].sel !== 3'b100 || apb_q[0].data !== x_data[0]) begin
      errors++;
      $display("FAIL slot2: got %0d accesses (first sel=%b), required 1 with sel=100 data=%h", apb_q.size(),
               apb_q.size() > 0 ? apb_q[0].sel : 3'bxxx, x_data[0]);
    end
    apb_q.delete();
    psel_cycles = 0;
    x_addr[0] = 32'h9000_0000; x_data[0] = $urandom;
    run_xfers(1);
    repeat (5) @(negedge Hclk);
    checks++;
    if (apb_q.size() != 0 || psel_cycles != 0) begin
      errors++;
      $display("FAIL oor_apb: got %0d accesses, %0d select cycles, required none", apb_q.size(), psel_cycles);
    end
    checks++;
    if (x_wait[0] != (ref_err(0) ? 1 : 0)) begin
      errors++;
      $display("FAIL oor_waits: got %0d, required %0d", x_wait[0], ref_err(0) ? 1 : 0);
    end
  endtask

  task automatic test_ignored;
    apb_q.delete();
    psel_cycles = 0;
    x_addr[0] = 32'h8000_0040; x_trans[0] = 2'b00; x_wr[0] = 1'b1; x_data[0] = $urandom;
    x_addr[1] = 32'h8400_0080; x_trans[1] = 2'b01; x_wr[1] = 1'b0;
    run_xfers(2);
    hready_en = 1'b0;
    x_addr[0] = 32'h8800_0100; x_trans[0] = 2'b10; x_wr[0] = 1'b1;
    run_xfers(1);
    repeat (5) @(negedge Hclk);
    hready_en = 1'b1;
    checks++;
    if (apb_q.size() != 0 || psel_cycles != 0) begin
      errors++;
      $display("FAIL ignored: got %0d accesses, %0d select cycles, required none", apb_q.size(), psel_cycles);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      prd_salt = $urandom;
      apb_q.delete();
      for (int i = 0; i < 12; i++) begin
        x_trans[i] = $urandom_range(0, 4) == 0 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        x_addr[i]  = $urandom_range(0, 7) == 0 ? 32'h9000_0000 + $urandom_range(0, 255)
                   : 32'h8000_0000 + ($urandom_range(0, 2) << 26) + $urandom_range(0, 32'h03FF_FFFF);
        x_wr[i]    = 1'($urandom_range(0, 1));
        x_data[i]  = $urandom;
      end
      run_xfers(12);
      repeat (6) @(negedge Hclk);
      build_exp(12);
      checks++;
      if (apb_q.size() != exp_q.size()) begin errors++; $display("FAIL random%0d_count: got %0d, required %0d", r, apb_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < apb_q.size()) begin
        checks++;
        if (apb_q[i].addr !== exp_q[i].addr || apb_q[i].wr !== exp_q[i].wr || apb_q[i].data !== exp_q[i].data || apb_q[i].sel !== exp_q[i].sel) begin
          errors++;
          $display("FAIL random%0d[%0d]: got %h/%b/%h/%b, required %h/%b/%h/%b", r, i, apb_q[i].addr, apb_q[i].wr, apb_q[i].data,
                   apb_q[i].sel, exp_q[i].addr, exp_q[i].wr, exp_q[i].data, exp_q[i].sel);
        end
      end
      for (int i = 0; i < 12; i++)
        if (x_trans[i][1] && !x_wr[i] && ref_sel(x_addr[i]) != 3'b000) begin
          checks++;
          if (x_rdata[i] !== ref_rd(x_addr[i])) begin
            errors++;
            $display("FAIL random%0d_rdata[%0d]: got %h, required %h", r, i, x_rdata[i], ref_rd(x_addr[i]));
          end
        end
    end
  endtask

  task automatic test_reset_mid;
    int g = 0;
    prd_salt = 32'h1234_5678;
    x_addr[0] = 32'h8800_0020; x_wr[0] = 1'b0; x_trans[0] = 2'b10;
    run_xfers(1);
    repeat (3) @(negedge Hclk);
    Htrans = 2'b10; Haddr = 32'h8000_0100; Hwrite = 1'b1;
    @(negedge Hclk);
    Htrans = 2'b00; Hwdata = 32'hCAFE_F00D;
    while (!Penable && g < 20) begin @(negedge Hclk); g++; end
    checks++;
    if (!Penable) begin errors++; $display("FAIL reset_mid_access: Penable got 0, required 1 before reset"); end
    #2 Hresetn = 1'b0;
    #1;
    checks++;
    if ({Hreadyout, Hresp, Hrdata, Pselx, Paddr, Pwrite, Penable, Pwdata} !== {1'b1, 1'b0, 32'h0, 3'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b resp=%b rdata=%h sel=%b paddr=%h pw=%b pen=%b pwdata=%h, required 1 0 0 000 0 0 0 0",
               Hreadyout, Hresp, Hrdata, Pselx, Paddr, Pwrite, Penable, Pwdata);
    end
    @(negedge Hclk);
    Hresetn = 1'b1;
    apb_q.delete();
    x_addr[0] = 32'h8400_0040; x_wr[0] = 1'b1; x_data[0] = $urandom; x_trans[0] = 2'b10;
    run_xfers(1);
    repeat (6) @(negedge Hclk);
    build_exp(1);
    checks++;
    if (apb_q.size() != 1 || apb_q[0].addr !== exp_q[0].addr || apb_q[0].data !== exp_q[0].data || apb_q[0].sel !== exp_q[0].sel) begin
      errors++;
      $display("FAIL post_reset_write: got %0d accesses (first addr=%h), required 1 at %h data=%h sel=%b", apb_q.size(),
               apb_q.size() > 0 ? apb_q[0].addr : 32'hx, exp_q[0].addr, exp_q[0].data, exp_q[0].sel);
    end
  endtask

  initial begin
    Hresetn = 1'b0; hready_en = 1'b1; Htrans = 2'b00; Haddr = '0; Hwdata = '0; Hwrite = 1'b0;
    prd_fix = 1'b0; prd_salt = '0;
    repeat (2) @(negedge Hclk);
    test_reset;
    Hresetn = 1'b1;
    repeat (2) @(negedge Hclk);
    test_pipelined_writes;
    test_read;
    test_slot2_and_oor;
    test_ignored;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
